// File: rtl/qspi_fast_read_master.sv
// rtl/qspi_fast_read_master.sv - QSPI fast-read master: opcode, address, dummy, 1/2/4-line burst read
// SCK runs at qspi_clk/2; io_out changes on SCK fall, io_in is sampled on SCK rise.
module qspi_fast_read_master #(
  parameter int ADDR_W      = 24,
  parameter int BURST_BYTES = 4,
  parameter int DUMMY_CYC   = 8,
  parameter int CS_IDLE_CYC = 4
) (
  input  logic              qspi_clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_mode,
  output logic              ack,
  output logic              busy,
  output logic [7:0]        rdata,
  output logic              rdata_vld,
  output logic              done,
  output logic              sck,
  output logic              csn,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);
  localparam int BITS_MAX = (ADDR_W > BURST_BYTES * 8) ? ADDR_W : BURST_BYTES * 8;
  localparam int CNT_W    = $clog2(BITS_MAX + 1);
  localparam int GAP_W    = $clog2(CS_IDLE_CYC + 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0);
  localparam logic [8:0]       BYTE_LAST  = 9'(BURST_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_IDLE_CYC - 1);
  localparam logic [3:0]       IO_OUT_RST = 4'b1100;
  localparam logic [3:0]       IO_OE_RST  = 4'b1101;
  localparam logic [1:0]       MODE_SINGLE = 2'b00;
  localparam logic [1:0]       MODE_DUAL   = 2'b01;
  localparam logic [1:0]       MODE_QUAD   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ready;
  logic              r_ph, w_ph_nxt;
  logic              r_csn, w_csn_nxt;
  logic [3:0]        r_io_out, w_io_out_nxt;
  logic [3:0]        r_io_oe, w_io_oe_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [7:0]        r_opc, w_opc_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [8:0]        r_byte, w_byte_nxt;
  logic [7:0]        r_rx, w_rx_nxt;
  logic [7:0]        r_rdata, w_rdata_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_done, w_done_nxt;
  logic              r_last, w_last_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic              w_ack;
  logic [1:0]        w_req_mode;
  logic [7:0]        w_opcode;
  logic [7:0]        w_rx_smp;
  logic [CNT_W-1:0]  w_mask;
  logic [3:0]        w_dummy_oe;

  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_ph     <= 1'b0;
      r_csn    <= 1'b1;
      r_io_out <= IO_OUT_RST;
      r_io_oe  <= IO_OE_RST;
      r_mode   <= MODE_SINGLE;
      r_opc    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_vld    <= 1'b0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= 1'b1;
      r_ph     <= w_ph_nxt;
      r_csn    <= w_csn_nxt;
      r_io_out <= w_io_out_nxt;
      r_io_oe  <= w_io_oe_nxt;
      r_mode   <= w_mode_nxt;
      r_opc    <= w_opc_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_byte   <= w_byte_nxt;
      r_rx     <= w_rx_nxt;
      r_rdata  <= w_rdata_nxt;
      r_vld    <= w_vld_nxt;
      r_done   <= w_done_nxt;
      r_last   <= w_last_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ph_nxt     = r_ph;
    w_csn_nxt    = r_csn;
    w_io_out_nxt = r_io_out;
    w_io_oe_nxt  = r_io_oe;
    w_mode_nxt   = r_mode;
    w_opc_nxt    = r_opc;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_byte_nxt   = r_byte;
    w_rx_nxt     = r_rx;
    w_rdata_nxt  = r_rdata;
    w_vld_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_last_nxt   = r_last;
    w_gap_nxt    = r_gap;
    w_ack        = 1'b0;
    w_opcode     = 8'h0B;
    w_req_mode   = (req_mode == 2'b11) ? MODE_SINGLE : req_mode;
    case (w_req_mode)
      MODE_DUAL: w_opcode = 8'h3B;
      MODE_QUAD: w_opcode = 8'h6B;
      default:   w_opcode = 8'h0B;
    endcase
    // w_mask marks the last sample of a byte for the active bus width
    case (r_mode)
      MODE_QUAD: begin w_rx_smp = {r_rx[3:0], io_in};      w_mask = CNT_W'(1); end
      MODE_DUAL: begin w_rx_smp = {r_rx[5:0], io_in[1:0]}; w_mask = CNT_W'(3); end
      default:   begin w_rx_smp = {r_rx[6:0], io_in[1]};   w_mask = CNT_W'(7); end
    endcase
    w_dummy_oe = (r_mode == MODE_QUAD) ? 4'b0000 : 4'b0001;

    case (r_state)
      S_IDLE: begin
        if (req && r_ready) begin
          w_ack        = 1'b1;
          w_mode_nxt   = w_req_mode;
          w_opc_nxt    = {w_opcode[6:0], 1'b0};
          w_addr_nxt   = req_addr;
          w_io_out_nxt = {2'b11, 1'b0, w_opcode[7]};
          w_io_oe_nxt  = IO_OE_RST;
          w_csn_nxt    = 1'b0;
          w_ph_nxt     = 1'b0;
          w_cnt_nxt    = '0;
          w_byte_nxt   = '0;
          w_last_nxt   = 1'b0;
          w_state_nxt  = S_CMD;
        end
      end
      S_CMD: begin
        w_ph_nxt = ~r_ph;
        if (r_ph) begin
          if (r_cnt == CMD_LAST) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = '0;
            w_io_out_nxt = {r_io_out[3:1], r_addr[ADDR_W-1]};
            w_addr_nxt   = {r_addr[ADDR_W-2:0], 1'b0};
          end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
            w_io_out_nxt = {r_io_out[3:1], r_opc[7]};
            w_opc_nxt    = {r_opc[6:0], 1'b0};
          end
        end
      end
      S_ADDR: begin
        w_ph_nxt = ~r_ph;
        if (r_ph) begin
          if (r_cnt == ADDR_LAST) begin
            w_cnt_nxt    = '0;
            w_io_out_nxt = {r_io_out[3:1], 1'b0};
            w_io_oe_nxt  = w_dummy_oe;
            w_state_nxt  = (DUMMY_CYC == 0) ? S_DATA : S_DUMMY;
          end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
            w_io_out_nxt = {r_io_out[3:1], r_addr[ADDR_W-1]};
            w_addr_nxt   = {r_addr[ADDR_W-2:0], 1'b0};
          end
        end
      end
      S_DUMMY: begin
        w_ph_nxt = ~r_ph;
        if (r_ph) begin
          if (r_cnt == DUMMY_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        w_ph_nxt = ~r_ph;
        if (!r_ph) begin
          w_rx_nxt  = w_rx_smp;
          w_cnt_nxt = r_cnt + 1'b1;
          if ((r_cnt & w_mask) == w_mask) begin
            w_rdata_nxt = w_rx_smp;
            w_vld_nxt   = 1'b1;
            w_byte_nxt  = r_byte + 1'b1;
            if (r_byte == BYTE_LAST) begin
              w_done_nxt = 1'b1;
              w_last_nxt = 1'b1;
            end
          end
        end else if (r_last) begin
          // finish the final SCK low before releasing the flash
          w_state_nxt  = S_GAP;
          w_csn_nxt    = 1'b1;
          w_io_out_nxt = IO_OUT_RST;
          w_io_oe_nxt  = IO_OE_RST;
          w_gap_nxt    = '0;
          w_last_nxt   = 1'b0;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ack       = w_ack;
  assign busy      = (r_state != S_IDLE);
  assign rdata     = r_rdata;
  assign rdata_vld = r_vld;
  assign done      = r_done;
  assign sck       = r_ph;
  assign csn       = r_csn;
  assign io_out    = r_io_out;
  assign io_oe     = r_io_oe;
endmodule

// File: tb/tb_qspi_fast_read_master.sv
// tb/tb_qspi_fast_read_master.sv - self-checking bench for qspi_fast_read_master
// Three builds: (24b,4B,8 dummy), (32b,8B,6 dummy), (24b,2B,0 dummy) share one flash model.
module tb_qspi_fast_read_master;
  function automatic int aw_of(input int c); return (c == 1) ? 32 : 24; endfunction
  function automatic int bb_of(input int c); return (c == 0) ? 4 : (c == 1) ? 8 : 2; endfunction
  function automatic int dc_of(input int c); return (c == 0) ? 8 : (c == 1) ? 6 : 0; endfunction
  function automatic int ci_of(input int c); return (c == 0) ? 4 : (c == 1) ? 3 : 2; endfunction

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_v;
  logic [2:0][31:0] addr_v;
  logic [2:0][1:0]  mode_v;
  logic [2:0][3:0]  io_in_v;
  logic [2:0]       ack_v, busy_v, vld_v, done_v, sck_v, csn_v;
  logic [2:0][7:0]  rdata_v;
  logic [2:0][3:0]  ioo_v, iooe_v;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cyc = 0;
  int done_cyc = 0;
  int hi_cnt  = 0;
  int last_hi = 0;
  logic [7:0] exp_b [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (csn_v[0]) hi_cnt <= hi_cnt + 1;
    else begin
      if (hi_cnt != 0) last_hi <= hi_cnt;
      hi_cnt <= 0;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int P_AW = aw_of(gi);
    qspi_fast_read_master #(
      .ADDR_W(P_AW), .BURST_BYTES(bb_of(gi)), .DUMMY_CYC(dc_of(gi)), .CS_IDLE_CYC(ci_of(gi))
    ) u_dut (
      .qspi_clk (clk),
      .rst_n    (rst_n),
      .req      (req_v[gi]),
      .req_addr (addr_v[gi][P_AW-1:0]),
      .req_mode (mode_v[gi]),
      .ack      (ack_v[gi]),
      .busy     (busy_v[gi]),
      .rdata    (rdata_v[gi]),
      .rdata_vld(vld_v[gi]),
      .done     (done_v[gi]),
      .sck      (sck_v[gi]),
      .csn      (csn_v[gi]),
      .io_out   (ioo_v[gi]),
      .io_oe    (iooe_v[gi]),
      .io_in    (io_in_v[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash side: sample j of the data phase carries stream bits j*w .. j*w+w-1, first bit on the highest lane
  function automatic logic [3:0] lanes(input int j, input int w);
    logic [3:0] v;
    int bi, lane;
    v = 4'($urandom);
    for (int k = 0; k < w; k++) begin
      bi = j * w + k;
      lane = (w == 1) ? 1 : w - 1 - k;
      v[lane] = exp_b[bi / 8][7 - bi % 8];
    end
    return v;
  endfunction

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) exp_b[i] = 8'($urandom);
  endtask

  bit aborted;

  // Called and returns at posedge+2. abort_rise>0 leaves after that many SCK rises (no checks).
  task automatic run_txn(input int c, input logic [31:0] addr, input logic [1:0] mode,
                         input bit keep_req, input int abort_rise);
    int aw, bb, dc, w, pre, nsmp, rises, nb, ndone, extra;
    logic [63:0] io0_cap, exp_cap;
    logic [7:0] opc;
    bit acked, oe_ok, prev_sck, fin;
    aw = aw_of(c); bb = bb_of(c); dc = dc_of(c);
    case (mode)
      2'b01:   begin opc = 8'h3B; w = 2; end
      2'b10:   begin opc = 8'h6B; w = 4; end
      default: begin opc = 8'h0B; w = 1; end
    endcase
    pre = 8 + aw + dc;
    nsmp = bb * 8 / w;
    aborted = 0;
    addr_v[c] = addr; mode_v[c] = mode; req_v[c] = 1'b1;
    acked = 0;
    for (int g = 0; g < 200 && !acked; g++) begin
      #1;
      if (ack_v[c]) begin
        acked = 1;
        ack_cyc = cyc;
        check("busy_at_ack", 64'(busy_v[c]), 64'd0);
      end else begin
        @(posedge clk); #2;
      end
    end
    check("ack_seen", 64'(acked), 64'd1);
    if (!acked) begin req_v[c] = 1'b0; return; end
    rises = 0; nb = 0; ndone = 0; extra = 0; io0_cap = '0; oe_ok = 1; prev_sck = 0; fin = 0;
    for (int g = 0; g < 4000 && !fin; g++) begin
      @(posedge clk); #2;
      if (!keep_req) req_v[c] = 1'b0;
      if (ack_v[c]) extra++;
      if (!csn_v[c]) begin
        if (sck_v[c] && !prev_sck) begin
          rises++;
          if (rises <= 8 + aw) io0_cap = {io0_cap[62:0], ioo_v[c][0]};
          if (rises > pre && iooe_v[c] !== ((w == 4) ? 4'b0000 : 4'b0001)) oe_ok = 0;
          if (abort_rise > 0 && rises == abort_rise) begin aborted = 1; return; end
        end
        if (!sck_v[c] && rises >= pre && rises - pre < nsmp) io_in_v[c] = lanes(rises - pre, w);
      end
      prev_sck = sck_v[c];
      if (vld_v[c]) begin
        if (nb < bb) check("rdata", 64'(rdata_v[c]), 64'(exp_b[nb]));
        nb++;
      end
      if (done_v[c]) begin
        ndone++;
        done_cyc = cyc;
        check("done_with_vld", 64'(vld_v[c]), 64'd1);
        check("done_on_last", 64'(nb), 64'(bb));
      end
      if (ndone > 0 && csn_v[c]) begin
        fin = 1;
        check("end_sck_low", 64'(sck_v[c]), 64'd0);
        check("end_io", {56'd0, iooe_v[c], ioo_v[c]}, {56'd0, 4'b1101, 4'b1100});
      end
    end
    exp_cap = (64'(opc) << aw) | (64'(addr) & ((64'd1 << aw) - 64'd1));
    check("opcode_addr", io0_cap, exp_cap);
    check("sck_count", 64'(rises), 64'(pre + nsmp));
    check("byte_count", 64'(nb), 64'(bb));
    check("done_count", 64'(ndone), 64'd1);
    check("oe_data", 64'(oe_ok), 64'd1);
    check("single_ack", 64'(extra), 64'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d1, c;
    logic [1:0] m;
    rst_n = 1'b0;
    req_v = '0; addr_v = '0; mode_v = '0; io_in_v = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_csn_sck", {62'd0, csn_v[k], sck_v[k]}, 64'b10);
      check("rst_io", {56'd0, iooe_v[k], ioo_v[k]}, {56'd0, 4'b1101, 4'b1100});
    end
    check("rst_outs", {52'd0, busy_v[0], vld_v[0], done_v[0], ack_v[0], rdata_v[0]}, 64'd0);
    req_v[0] = 1'b1; #1;
    check("rst_no_ack", 64'(ack_v[0]), 64'd0);
    req_v[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h0F; exp_b[3] = 8'hF0;
    run_txn(0, 32'h000104, 2'b00, 0, 0);
    run_txn(0, 32'h000104, 2'b01, 0, 0);
    fill_rand(4);
    run_txn(0, $urandom, 2'b11, 0, 0);
    fill_rand(8);
    run_txn(1, $urandom, 2'b10, 0, 0);
    fill_rand(8);
    run_txn(1, $urandom, 2'b01, 0, 0);
    fill_rand(2);
    run_txn(2, $urandom, 2'b00, 0, 0);
    fill_rand(2);
    run_txn(2, $urandom, 2'b10, 0, 0);

    fill_rand(4);
    run_txn(0, $urandom, 2'b00, 1, 0);
    d1 = done_cyc;
    fill_rand(4);
    run_txn(0, $urandom, 2'b10, 0, 0);
    check("b2b_ack_gap", 64'(ack_cyc - d1), 64'(ci_of(0) + 1));
    check("b2b_csn_high", 64'(last_hi >= ci_of(0)), 64'd1);

    fill_rand(4);
    run_txn(0, $urandom, 2'b00, 0, 18);
    check("abort_reached", 64'(aborted), 64'd1);
    rst_n = 1'b0; #1;
    check("abort_csn_sck_busy", {61'd0, csn_v[0], sck_v[0], busy_v[0]}, 64'b100);
    check("abort_io", {56'd0, iooe_v[0], ioo_v[0]}, {56'd0, 4'b1101, 4'b1100});
    req_v[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("abort_quiet", {61'd0, done_v[0], vld_v[0], ack_v[0]}, 64'd0);
    end
    req_v[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #2;
    fill_rand(4);
    run_txn(0, $urandom, 2'b01, 0, 0);

    for (int it = 0; it < 6; it++) begin
      c = $urandom_range(0, 2);
      m = 2'($urandom_range(0, 3));
      fill_rand(bb_of(c));
      run_txn(c, $urandom, m, 0, 0);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qspi_fast_read_master.md
Name: qspi_fast_read_master

Overview:
Synthesizable QSPI flash read master; parametrised successor of the single-line fast-read model. It accepts a read request (address) on a req/ack handshake and runs a complete flash transaction: opcode, address, dummy cycles, burst data. Data returns on 1, 2 or 4 lines, selected per request. Each received byte is presented to the downstream buffer (e.g. SDRAM write path) with a one-cycle valid strobe.

Parameters:
ADDR_W, 24, flash address width in bits (24 or 32), always sent on io0 MSB first
BURST_BYTES, 4, bytes read per transaction (1..256)
DUMMY_CYC, 8, SCK cycles between the address and data phases (0..15)
CS_IDLE_CYC, 4, minimum qspi_clk cycles csn stays high between transactions (>=2)

Ports:
qspi_clk  in  1  system clock; SCK runs at qspi_clk/2
rst_n  in  1  asynchronous active-low reset
req  in  1  read request, level; held until ack
req_addr  in  ADDR_W  start address, sampled with ack
req_mode  in  2  00 single (0x0B), 01 dual-out (0x3B), 10 quad-out (0x6B), 11 treated as 00
ack  out  1  one-cycle pulse: request accepted
busy  out  1  high from ack until csn returns high after CS_IDLE_CYC
rdata  out  8  received byte, MSB first as shifted
rdata_vld  out  1  one-cycle pulse per completed byte
done  out  1  one-cycle pulse when the last byte has been delivered
sck  out  1  flash serial clock, idle low (SPI mode 0)
csn  out  1  flash chip select, active low
io_out  out  4  pad output data; io0=DI, io2=WPn, io3=HOLDn in single/dual
io_oe  out  4  pad output enables
io_in  in  4  pad input data; io1=DO

Behaviour:
- Reset (async, any state): state=IDLE; csn=1, sck=0, ack=0, busy=0, rdata=0, rdata_vld=0, done=0; io_out=4'b1100, io_oe=4'b1101 (WPn/HOLDn driven high, io1 input).
- Bit timing: internal phase bit ph toggles each qspi_clk while state is CMD..DATA; sck=ph. Master updates io_out on the clk edge taking ph 1->0 (SCK fall). Master samples io_in on the clk edge taking ph 0->1 (SCK rise). One SCK cycle = 2 qspi_clk.
- States: IDLE, CMD, ADDR, DUMMY, DATA, GAP.
- IDLE: if req=1 and busy=0: pulse ack, latch addr and mode (11->00), load the opcode, drive csn=0, put opcode bit7 on io0, go CMD. ack is asserted in the same cycle as the req it answers; at most one ack per transaction.
- CMD: 8 SCK on io0, MSB first -> ADDR.
- ADDR: ADDR_W SCK on io0, MSB first -> DUMMY, or DATA if DUMMY_CYC=0.
- DUMMY: DUMMY_CYC SCK. io_oe drops to 4'b0001 (single/dual) or 4'b0000 (quad) at the first falling edge of the dummy phase; io0 holds 0 in single/dual.
- DATA: BURST_BYTES*8/W SCK, where W=1, 2 or 4.
  - Single: shift in io1.
  - Dual: shift in {io1,io0}.
  - Quad: shift in io_in[3:0].
  - On the sample that completes a byte: rdata updates and rdata_vld pulses 1 cycle later (registered); byte count increments.
  - The last byte additionally pulses done together with its rdata_vld. Then csn=1, sck=0, and io_out/io_oe return to reset values -> GAP.
- GAP: count CS_IDLE_CYC cycles with csn=1, then busy=0 -> IDLE. A req held across GAP is acked on the first IDLE cycle.
- Counters: bit counter sized for max(ADDR_W, BURST_BYTES*8); byte counter wraps only via transaction end. Address is not auto-incremented; the requester supplies each address.
- req deasserted mid-transaction: no effect; the transaction completes. Reset mid-transaction: immediate abort to reset values; no done.

Test Plan:
- Single mode, req_addr=24'h000104, flash model returns A5,3C,0F,F0 -> io0 serialises 0x0B then 0x000104. 8 dummy SCK, then 4 rdata_vld pulses with A5,3C,0F,F0. done on the 4th pulse. Total SCK count = 8+24+8+32 = 72.
- Dual mode, same data -> opcode 0x3B, 16 data SCK. io_oe=0001 during data. Bytes match.
- Quad mode, BURST_BYTES=8, DUMMY_CYC=6 -> opcode 0x6B, io_oe=0000 from the dummy phase. 16 data SCK, 8 bytes in order.
- Back-to-back: req held high through two transactions -> second ack exactly CS_IDLE_CYC+1 cycles after the first done. csn high >=4 cycles between them.
- Async reset asserted in the middle of ADDR -> csn=1, sck=0, busy=0 immediately; no done. A new req after reset completes normally.
- req_mode=11 -> behaves as single mode (opcode 0x0B). DUMMY_CYC=0 build -> DATA follows ADDR directly.
